// File: rtl/ring_buffer_payload_reader_pkg.sv
// ---------------------------------------------------------------------------
// ring_buffer_payload_reader_pkg
// Shared types and constants for the ring-buffer payload reader slice.
//   reader_state_t : read-engine FSM states (IDLE -> HDR -> PAYLOAD -> IDLE)
//   SKID_DEPTH     : number of entries in the output skid buffer
//   HDR_WORDS      : header words for the default 32-bit sequence / 8-bit word
//   hdrWordCount() : header words for any SEQ_W / N combination
// ---------------------------------------------------------------------------
package ring_buffer_payload_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } reader_state_t;

  localparam int SKID_DEPTH    = 2;
  localparam int DEFAULT_N     = 8;
  localparam int DEFAULT_SEQ_W = 32;
  localparam int HDR_WORDS     = DEFAULT_SEQ_W / DEFAULT_N;

  // The sequence header is sent as whole data words, MSB first.
  function automatic int hdrWordCount(input int seqW, input int n);
    return seqW / n;
  endfunction

endpackage

// File: rtl/ring_buffer_payload_reader_if.sv
// ---------------------------------------------------------------------------
// ring_buffer_payload_reader_if
// Groups the two buses of the payload reader:
//   ring_buffer read port : rb_rd_en, rb_rd_valid, rb_rd_data, rb_fill
//   AXI-stream output     : m_tdata, m_tvalid, m_tready, m_tlast
// Modports:
//   master : the reader (drives rb_rd_en and the stream)
//   slave  : the environment (ring_buffer + downstream stream consumer)
// ---------------------------------------------------------------------------
interface ring_buffer_payload_reader_if
  import ring_buffer_payload_reader_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int FILL_W = 11
);

  logic              rb_rd_en;
  logic              rb_rd_valid;
  logic [N-1:0]      rb_rd_data;
  logic [FILL_W-1:0] rb_fill;

  logic [N-1:0]      m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  modport master (
    output rb_rd_en,
    input  rb_rd_valid,
    input  rb_rd_data,
    input  rb_fill,
    output m_tdata,
    output m_tvalid,
    input  m_tready,
    output m_tlast
  );

  modport slave (
    input  rb_rd_en,
    output rb_rd_valid,
    output rb_rd_data,
    output rb_fill,
    input  m_tdata,
    input  m_tvalid,
    output m_tready,
    input  m_tlast
  );

endinterface

// File: rtl/ring_buffer_payload_reader_axis_skid2.sv
// ---------------------------------------------------------------------------
// axis_skid2
// Two-entry FIFO whose head entry is presented directly as registered
// AXI-stream outputs. Each entry carries {last, data}.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write pushWord_i this cycle (ignored when full with no pop)
//   pushWord_i   : {last, data} to store
//   ready_i      : downstream ready; a pop happens on valid_o && ready_i
//   valid_o      : head entry present
//   word_o       : head entry {last, data}, stable until popped
//   count_o      : current occupancy (0..2)
// ---------------------------------------------------------------------------
module axis_skid2
  import ring_buffer_payload_reader_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] pushWord_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] word_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [SKID_DEPTH];
  logic         wrPtr_q;
  logic         rdPtr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         pop;
  logic         pushOk;

  assign valid_o = (count_q != 2'd0);
  assign word_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign pop     = valid_o & ready_i;

  // A push into a full buffer is only accepted when the head leaves in the
  // same cycle, which keeps one beat per cycle flowing at full occupancy.
  assign pushOk  = push_i & ((count_q != 2'(SKID_DEPTH)) | pop);

  // Occupancy tracks the net effect of this cycle's push and pop.
  always_comb begin
    count_d = count_q;
    case ({pushOk, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; the head word is only rewritten when the slot it
  // occupies has been popped, so the output is stable during stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (pushOk) begin
        mem_q[wrPtr_q] <= pushWord_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ring_buffer_payload_reader.sv
// ---------------------------------------------------------------------------
// ring_buffer_payload_reader
// Read-side engine of the UDP packetizer ring buffer (rclk domain). Once
// PAYLOAD_WORDS words are stored it emits one frame on a byte-wide stream:
// SEQ_W/N sequence-number header words (MSB first) followed by PAYLOAD_WORDS
// words drained from the ring buffer. A 2-entry skid absorbs backpressure.
// Ports:
//   rclk, rst     : sole clock, asynchronous active-high reset
//   bus (master)  : ring_buffer read port and AXI-stream output
//   frame_seq     : sequence number of the next frame to be sent
//   busy          : high from frame start until the tlast handshake
//   err_underrun  : sticky, a read returned without rb_rd_valid
// ---------------------------------------------------------------------------
module ring_buffer_payload_reader
  import ring_buffer_payload_reader_pkg::*;
#(
  parameter int N             = 8,
  parameter int FILL_W        = 11,
  parameter int PAYLOAD_WORDS = 256,
  parameter int SEQ_W         = 32
) (
  input  logic                   rclk,
  input  logic                   rst,
  ring_buffer_payload_reader_if.master bus,
  output logic [SEQ_W-1:0]       frame_seq,
  output logic                   busy,
  output logic                   err_underrun
);

  localparam int HdrWords = hdrWordCount(SEQ_W, N);
  localparam int HdrIdxW  = (HdrWords > 1) ? $clog2(HdrWords) : 1;

  reader_state_t     state_q, state_d;
  logic [HdrIdxW-1:0] hdrIdx_q, hdrIdx_d;
  logic [FILL_W-1:0] readsIssued_q, readsIssued_d;
  logic              inFlight_q, inFlight_d;
  logic              lastInFlight_q, lastInFlight_d;
  logic [SEQ_W-1:0]  seqCount_q, seqCount_d;
  logic [SEQ_W-1:0]  hdrSeq_q, hdrSeq_d;
  logic              err_q, err_d;

  logic [1:0]        skidCount;
  logic              skidValid;
  logic [N:0]        skidWord;
  logic              popFire;
  logic [1:0]        occAfterPop;
  logic              pushEn;
  logic [N-1:0]      pushData;
  logic              pushLast;
  logic              rdEn;
  logic              readsLeft;
  logic              hdrLast;
  logic [SEQ_W-1:0]  hdrShift;

  assign popFire     = skidValid & bus.m_tready;
  // Occupancy the skid will have after this cycle's pop, before any push.
  assign occAfterPop = skidCount - {1'b0, popFire};
  assign readsLeft   = (readsIssued_q < FILL_W'(PAYLOAD_WORDS));
  assign hdrLast     = (hdrIdx_q == HdrIdxW'(HdrWords - 1));
  // Shifting left brings the current header word to the top, MSB word first.
  assign hdrShift    = hdrSeq_q << (32'(hdrIdx_q) * N);

  // Next-state and datapath control. A read may be issued only if the skid
  // will still have room for it when it returns next cycle: the occupancy
  // after this cycle's pop plus this cycle's push must leave a free slot.
  // Counting the pop this cycle is what allows back-to-back reads at full
  // rate. Payload reads start on the last header push so the first payload
  // word returns in PAYLOAD and can never overtake a header word.
  always_comb begin
    state_d       = state_q;
    hdrIdx_d      = hdrIdx_q;
    readsIssued_d = readsIssued_q;
    hdrSeq_d      = hdrSeq_q;
    seqCount_d    = seqCount_q;
    err_d         = err_q;
    pushEn        = 1'b0;
    pushData      = '0;
    pushLast      = 1'b0;
    rdEn          = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.rb_fill >= FILL_W'(PAYLOAD_WORDS)) begin
          state_d       = HDR;
          hdrSeq_d      = seqCount_q;
          hdrIdx_d      = '0;
          readsIssued_d = '0;
        end
      end

      HDR: begin
        if (occAfterPop != 2'd2) begin
          pushEn   = 1'b1;
          pushData = hdrShift[SEQ_W-1 -: N];
          hdrIdx_d = hdrIdx_q + HdrIdxW'(1);
          if (hdrLast) begin
            state_d = PAYLOAD;
            rdEn    = readsLeft & (occAfterPop == 2'd0);
          end
        end
      end

      PAYLOAD: begin
        // A missing rb_rd_valid is replaced by a zero word so the frame
        // keeps its length.
        if (inFlight_q) begin
          pushEn   = 1'b1;
          pushData = bus.rb_rd_valid ? bus.rb_rd_data : '0;
          pushLast = lastInFlight_q;
          if (!bus.rb_rd_valid) begin
            err_d = 1'b1;
          end
        end
        rdEn = readsLeft & ((occAfterPop + {1'b0, inFlight_q}) < 2'd2);
        if (popFire && skidWord[N]) begin
          state_d    = IDLE;
          seqCount_d = seqCount_q + SEQ_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (rdEn) begin
      readsIssued_d = readsIssued_q + FILL_W'(1);
    end
  end

  // Every read returns exactly one cycle later; remember whether it is the
  // final payload word so it can carry tlast into the skid.
  assign inFlight_d     = rdEn;
  assign lastInFlight_d = rdEn & (readsIssued_q == FILL_W'(PAYLOAD_WORDS - 1));

  // State register; reset drops any partial frame.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      hdrIdx_q       <= '0;
      readsIssued_q  <= '0;
      inFlight_q     <= 1'b0;
      lastInFlight_q <= 1'b0;
      seqCount_q     <= '0;
      hdrSeq_q       <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdrIdx_q       <= hdrIdx_d;
      readsIssued_q  <= readsIssued_d;
      inFlight_q     <= inFlight_d;
      lastInFlight_q <= lastInFlight_d;
      seqCount_q     <= seqCount_d;
      hdrSeq_q       <= hdrSeq_d;
      err_q          <= err_d;
    end
  end

  axis_skid2 #(
    .W (N + 1)
  ) u_skid (
    .clk        (rclk),
    .rst        (rst),
    .push_i     (pushEn),
    .pushWord_i ({pushLast, pushData}),
    .ready_i    (bus.m_tready),
    .valid_o    (skidValid),
    .word_o     (skidWord),
    .count_o    (skidCount)
  );

  assign bus.rb_rd_en = rdEn;
  assign bus.m_tvalid = skidValid;
  assign bus.m_tdata  = skidWord[N-1:0];
  assign bus.m_tlast  = skidWord[N];
  assign frame_seq    = seqCount_q;
  assign busy         = (state_q != IDLE);
  assign err_underrun = err_q;

endmodule

// File: tb/tb_ring_buffer_payload_reader.sv
// ---------------------------------------------------------------------------
// tb_ring_buffer_payload_reader
// Directed bench: a ring-buffer model feeds the reader, frames are queued as
// expected beats when stimulus is applied, and a monitor pops and compares
// every stream handshake. A second instance with an 8-bit sequence and a
// 4-word payload exercises the sequence counter wrap.
// ---------------------------------------------------------------------------
module tb_ring_buffer_payload_reader;

  localparam int N      = 8;
  localparam int FILL_W = 11;
  localparam int P      = 256;
  localparam int SEQ_W  = 32;
  localparam int HDR    = SEQ_W / N;

  logic rclk = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  always #5 rclk = ~rclk;

  ring_buffer_payload_reader_if #(.N(N), .FILL_W(FILL_W)) bus ();
  ring_buffer_payload_reader_if #(.N(N), .FILL_W(FILL_W)) bus2 ();

  logic [SEQ_W-1:0] frameSeq;
  logic             busy;
  logic             errUnderrun;
  logic [7:0]       frameSeq2;
  logic             busy2;
  logic             errUnderrun2;

  ring_buffer_payload_reader #(
    .N(N), .FILL_W(FILL_W), .PAYLOAD_WORDS(P), .SEQ_W(SEQ_W)
  ) dut (
    .rclk         (rclk),
    .rst          (rst),
    .bus          (bus),
    .frame_seq    (frameSeq),
    .busy         (busy),
    .err_underrun (errUnderrun)
  );

  ring_buffer_payload_reader #(
    .N(N), .FILL_W(FILL_W), .PAYLOAD_WORDS(4), .SEQ_W(8)
  ) dutWrap (
    .rclk         (rclk),
    .rst          (rst2),
    .bus          (bus2),
    .frame_seq    (frameSeq2),
    .busy         (busy2),
    .err_underrun (errUnderrun2)
  );

  int checks = 0;
  int failures = 0;
  int cycleCount = 0;
  int fillLevel = 0;
  int readPtr = 0;
  int suppressIdx = -1;
  bit rdEnSeen = 1'b0;
  bit randomReady = 1'b0;

  logic [N:0] expQ[$];
  logic [N:0] expWord;
  int expPtr = 0;
  int tlastCount = 0;
  int beatsInFrame = 0;
  int rdEnCount = 0;
  int frameFirstCycle = -1;
  bit prevStall = 1'b0;
  logic [N:0] prevWord = '0;
  bit wrapDone = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Store nWords more words in the modelled ring buffer.
  task automatic applyStimulus(input int nWords);
    fillLevel += nWords;
    bus.rb_fill = FILL_W'(fillLevel);
  endtask

  // Queue the beats of one frame: header then payload continuing from expPtr.
  task automatic pushExpectedFrame(input logic [SEQ_W-1:0] seq, input int zeroAt);
    logic [SEQ_W-1:0] s;
    logic [N-1:0] d;
    for (int h = 0; h < HDR; h++) begin
      s = seq << (N * h);
      expQ.push_back({1'b0, s[SEQ_W-1 -: N]});
    end
    for (int k = 0; k < P; k++) begin
      d = (k == zeroAt) ? '0 : N'(expPtr + k);
      expQ.push_back({(k == P - 1), d});
    end
    expPtr += P;
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (tlastCount < target && n < budget) begin
      @(posedge rclk);
      n++;
    end
    checkOutput("frame_done_timeout", 64'(tlastCount), 64'(target));
    #2;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_en"},  64'(bus.rb_rd_en), 64'(0));
    checkOutput({tag, "_tvalid"}, 64'(bus.m_tvalid), 64'(0));
    checkOutput({tag, "_tlast"},  64'(bus.m_tlast),  64'(0));
    checkOutput({tag, "_tdata"},  64'(bus.m_tdata),  64'(0));
    checkOutput({tag, "_busy"},   64'(busy),         64'(0));
    checkOutput({tag, "_seq"},    64'(frameSeq),     64'(0));
    checkOutput({tag, "_err"},    64'(errUnderrun),  64'(0));
  endtask

  // Ring-buffer model and ready driver: a read seen before the edge returns
  // data equal to its read index just after the edge.
  initial begin
    bus.rb_rd_valid = 1'b0;
    bus.rb_rd_data  = '0;
    bus.rb_fill     = '0;
    bus.m_tready    = 1'b1;
    forever begin
      @(posedge rclk);
      cycleCount++;
      #1;
      if (rdEnSeen) begin
        bus.rb_rd_valid = (readPtr != suppressIdx);
        bus.rb_rd_data  = (readPtr != suppressIdx) ? N'(readPtr) : 8'hAA;
        readPtr++;
        fillLevel--;
      end else begin
        bus.rb_rd_valid = 1'b0;
        bus.rb_rd_data  = '0;
      end
      bus.rb_fill  = FILL_W'(fillLevel);
      bus.m_tready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every handshake with the scoreboard and checks that a
  // stalled beat is held unchanged.
  initial begin
    forever begin
      @(negedge rclk);
      rdEnSeen = bus.rb_rd_en;
      if (bus.rb_rd_en) rdEnCount++;
      if (rst) begin
        prevStall    = 1'b0;
        beatsInFrame = 0;
      end else begin
        if (prevStall) begin
          checkOutput("stall_hold", 64'({bus.m_tvalid, bus.m_tlast, bus.m_tdata}),
                      64'({1'b1, prevWord}));
        end
        if (bus.m_tvalid && beatsInFrame == 0 && frameFirstCycle < 0) begin
          frameFirstCycle = cycleCount;
        end
        if (bus.m_tvalid && bus.m_tready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_beat", 64'(1), 64'(0));
          end else begin
            expWord = expQ.pop_front();
            checkOutput($sformatf("beat%0d_frame%0d", beatsInFrame + 1, tlastCount),
                        64'({bus.m_tlast, bus.m_tdata}), 64'(expWord));
          end
          beatsInFrame++;
          if (bus.m_tlast) begin
            tlastCount++;
            checkOutput("frame_len", 64'(beatsInFrame), 64'(HDR + P));
            beatsInFrame = 0;
          end
        end
        prevStall = bus.m_tvalid && !bus.m_tready;
        prevWord  = {bus.m_tlast, bus.m_tdata};
      end
    end
  end

  // Wrap instance: 257 frames with an 8-bit sequence counter.
  initial begin
    int frames = 0;
    int n = 0;
    bit atStart = 1'b1;
    bit seen2 = 1'b0;
    logic [7:0] hdr256 = 8'h11;
    logic [7:0] hdr257 = 8'h11;
    bus2.rb_rd_valid = 1'b0;
    bus2.rb_rd_data  = '0;
    bus2.rb_fill     = 11'd1023;
    bus2.m_tready    = 1'b1;
    repeat (3) @(posedge rclk);
    #2 rst2 = 1'b0;
    while (frames < 257 && n < 5000) begin
      @(negedge rclk);
      n++;
      seen2 = bus2.rb_rd_en;
      if (bus2.m_tvalid && bus2.m_tready) begin
        if (atStart) begin
          if (frames == 255) hdr256 = bus2.m_tdata;
          if (frames == 256) hdr257 = bus2.m_tdata;
          atStart = 1'b0;
        end
        if (bus2.m_tlast) begin
          frames++;
          atStart = 1'b1;
        end
      end
      @(posedge rclk);
      #1;
      bus2.rb_rd_valid = seen2;
      bus2.rb_rd_data  = 8'h5A;
    end
    checkOutput("wrap_frames", 64'(frames), 64'(257));
    checkOutput("wrap_hdr256", 64'(hdr256), 64'(8'hFF));
    checkOutput("wrap_hdr257", 64'(hdr257), 64'(8'h00));
    checkOutput("wrap_frame_seq", 64'(frameSeq2), 64'(8'h01));
    wrapDone = 1'b1;
  end

  initial begin
    int bad;
    int n;
    int startCycle;
    int tlastBase;

    rst = 1'b1;
    repeat (3) @(posedge rclk);
    #2;
    checkAllZero("reset");
    rst = 1'b0;

    // Single frame at full rate with data 0..255.
    $display("[TB] frame with fill 256, tready=1");
    @(posedge rclk); #2;
    rdEnCount       = 0;
    frameFirstCycle = -1;
    pushExpectedFrame(0, -1);
    startCycle = cycleCount;
    applyStimulus(256);
    waitFrames(1, 2000);
    checkOutput("first_beat_latency", 64'(frameFirstCycle - startCycle), 64'(2));
    checkOutput("rd_en_pulses", 64'(rdEnCount), 64'(P));
    checkOutput("seq_after_f0", 64'(frameSeq), 64'(1));
    checkOutput("err_after_f0", 64'(errUnderrun), 64'(0));
    checkOutput("busy_after_f0", 64'(busy), 64'(0));
    checkOutput("queue_empty_f0", 64'(expQ.size()), 64'(0));

    // One word short: nothing may start until the last word arrives.
    $display("[TB] fill 255 held, then 256");
    applyStimulus(255);
    bad = 0;
    repeat (1000) begin
      @(negedge rclk);
      if (bus.rb_rd_en || bus.m_tvalid || busy) bad++;
    end
    checkOutput("quiet_at_255", 64'(bad), 64'(0));
    @(posedge rclk); #2;
    pushExpectedFrame(1, -1);
    applyStimulus(1);
    @(negedge rclk);
    checkOutput("busy_decision_cycle", 64'(busy), 64'(0));
    @(negedge rclk);
    checkOutput("busy_after_decision", 64'(busy), 64'(1));
    waitFrames(2, 2000);
    checkOutput("seq_after_f1", 64'(frameSeq), 64'(2));

    // Two frames back to back.
    $display("[TB] fill 512, two frames");
    pushExpectedFrame(2, -1);
    pushExpectedFrame(3, -1);
    applyStimulus(512);
    waitFrames(4, 3000);
    checkOutput("seq_after_f3", 64'(frameSeq), 64'(4));

    // Random backpressure over three frames.
    $display("[TB] random tready over three frames");
    randomReady = 1'b1;
    pushExpectedFrame(4, -1);
    pushExpectedFrame(5, -1);
    pushExpectedFrame(6, -1);
    applyStimulus(768);
    waitFrames(7, 8000);
    randomReady = 1'b0;
    checkOutput("seq_after_f6", 64'(frameSeq), 64'(7));
    checkOutput("err_after_f6", 64'(errUnderrun), 64'(0));

    // Tenth read of the frame returns without valid.
    $display("[TB] underrun on read 10");
    suppressIdx = expPtr + 9;
    pushExpectedFrame(7, 9);
    applyStimulus(256);
    waitFrames(8, 2000);
    checkOutput("err_set", 64'(errUnderrun), 64'(1));
    repeat (50) @(posedge rclk);
    #2;
    checkOutput("err_sticky", 64'(errUnderrun), 64'(1));
    checkOutput("seq_after_f7", 64'(frameSeq), 64'(8));

    // Reset in the middle of a frame, then a fresh frame from sequence 0.
    $display("[TB] reset at beat 100");
    pushExpectedFrame(8, -1);
    applyStimulus(256);
    n = 0;
    while (beatsInFrame < 100 && n < 2000) begin
      @(negedge rclk);
      n++;
    end
    checkOutput("reached_beat100", 64'(beatsInFrame >= 100), 64'(1));
    #2 rst = 1'b1;
    #1;
    checkAllZero("midframe_reset");
    expQ.delete();
    repeat (3) @(posedge rclk);
    #2;
    expPtr = readPtr;
    applyStimulus(256);
    pushExpectedFrame(0, -1);
    tlastBase = tlastCount;
    rst = 1'b0;
    waitFrames(tlastBase + 1, 2000);
    checkOutput("seq_after_reset_frame", 64'(frameSeq), 64'(1));
    checkOutput("err_after_reset", 64'(errUnderrun), 64'(0));

    n = 0;
    while (!wrapDone && n < 10000) begin
      @(posedge rclk);
      n++;
    end
    checkOutput("wrap_done", 64'(wrapDone), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_buffer_payload_reader.md
Name: ring_buffer_payload_reader

Overview:
Read-side engine for ring_buffer in the UDP packetizer, running in the ethernet (rclk) domain.
- Watches the buffer fill level.
- When a full payload is stored, emits one frame as a byte-wide AXI-stream: a sequence-number header, then PAYLOAD_WORDS words drained from the buffer.
- Downstream UDP/IP header insertion consumes this stream; backpressure is absorbed by a 2-entry skid buffer.

Parameters:
N, 8, data word width (matches ring_buffer); SEQ_W must be a multiple of N
FILL_W, 11, width of ring_buffer fill count (1024-deep buffer)
PAYLOAD_WORDS, 256, data words per frame, 1..2**(FILL_W-1)
SEQ_W, 32, frame sequence counter width; header is SEQ_W/N words, MSB first

Ports:
rclk  in  1  ethernet clock, sole clock
rst  in  1  asynchronous, active-high reset
rb_rd_en  out  1  read strobe to ring_buffer
rb_rd_valid  in  1  ring_buffer data valid, exactly 1 cycle after rb_rd_en
rb_rd_data  in  N  ring_buffer read data
rb_fill  in  FILL_W  ring_buffer fill count (words stored, rclk domain)
m_tdata  out  N  stream data
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready
m_tlast  out  1  last beat of frame
frame_seq  out  SEQ_W  sequence number of the next frame to be sent
busy  out  1  high from frame start until the tlast handshake
err_underrun  out  1  sticky; set when rb_rd_valid is missing after rb_rd_en

Behaviour:
- Reset (async, any time, including mid-frame): all outputs 0 immediately; FSM to IDLE; skid emptied; sequence counter 0; err_underrun cleared. No partial frame resumes after reset.
- FSM IDLE -> HDR -> PAYLOAD -> IDLE.
- IDLE: when rb_fill >= PAYLOAD_WORDS, go to HDR next cycle, latch the sequence value, busy=1. rb_fill is sampled only in IDLE.
- HDR: push SEQ_W/N header words (seq[SEQ_W-1 -: N] first) into the skid.
- HDR and PAYLOAD: issue payload reads, prefetch allowed during HDR, but header words always leave the stream before any payload word.
- Read issue rule: rb_rd_en=1 only while (reads_issued < PAYLOAD_WORDS) and (skid occupancy + reads in flight < 2).
- At most one read in flight; it returns the following cycle.
- Underrun: rb_rd_en without rb_rd_valid the next cycle -> set err_underrun; push 0 in place of the missing word so frame length is preserved.
- PAYLOAD word k (k = 0..PAYLOAD_WORDS-1) is the k-th word read; m_tlast=1 only on word PAYLOAD_WORDS-1.
- Frame end: on the tlast handshake, seq increments (wraps modulo 2**SEQ_W), busy=0, FSM to IDLE.
- A following frame can start 1 cycle later (IDLE decision cycle), so inter-frame gap is at least 1 cycle.
- AXI-stream rules:
  - m_tdata/m_tlast held stable while m_tvalid && !m_tready.
  - m_tvalid never drops without a handshake.
  - A skid entry pops on m_tvalid && m_tready.
  - Full throughput of 1 beat/cycle when m_tready=1.
- Latency: IDLE with sufficient fill -> first header beat valid 2 cycles later (1 cycle decision, 1 cycle skid register).
- Frame length: exactly SEQ_W/N + PAYLOAD_WORDS beats; exactly PAYLOAD_WORDS rb_rd_en pulses per frame.
- frame_seq updates the cycle after the tlast handshake.

Decomposition:
- ring_buffer_pkg: reader_state_t enum (IDLE, HDR, PAYLOAD), HDR_WORDS = SEQ_W/N, SKID_DEPTH = 2.
- Sub-module axis_skid2: 2-entry N+1-bit (data+last) skid FIFO with push/pop, occupancy count, and AXI-stream output registers.

Test Plan:
- Fill = 256 (data 0..255), tready=1 -> beats 00,00,00,00,00..FF; tlast on beat 260; 256 rd_en pulses; frame_seq 0->1; err_underrun=0.
- Fill = 255 for 1000 cycles -> no rd_en, m_tvalid=0, busy=0. Fill 256 then -> frame starts 1 cycle later.
- Fill = 512, tready=1 -> two frames with headers 00000000 and 00000001, gap of 1 cycle, payloads 0..255 twice.
- tready random (50%) over 3 frames -> stream identical to the tready=1 case; skid occupancy + in-flight never exceeds 2; tdata stable during stalls.
- Suppress rb_rd_valid on read #10 -> err_underrun=1 and stays set; beat 14 = 00; frame still 260 beats with tlast on 260.
- Assert rst at beat 100 of a frame -> outputs 0 asynchronously. Release with fill >= 256 -> new frame with header 00000000.
- SEQ_W=8, 257 frames -> header of the 257th frame = 00 (wrap).
